// File: rtl/svn_seg_pkg.sv
// svn_seg_pkg: shared constants for the seven-segment scan driver (blank pattern, glyph table, digit limits).
package svn_seg_pkg;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam int MIN_DIGITS = 1;
   localparam int MAX_DIGITS = 8;
   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };
endpackage

// File: rtl/svn_seg_glyph_rom.sv
// svn_seg_glyph_rom: combinational hex nibble to active-low cathode pattern lookup.
module svn_seg_glyph_rom
   import svn_seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   assign seg = GLYPH[nib];
endmodule

// File: rtl/svn_seg_scan_driver.sv
// svn_seg_scan_driver: time-multiplexed common-anode seven-segment driver with blank gap and leading-zero suppression.
// Define SVN_SEG_PWM_EN to add a 4-bit brightness input that PWM-gates the anodes.
module svn_seg_scan_driver
   import svn_seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    lz_blank,
`ifdef SVN_SEG_PWM_EN
   input  logic [3:0]              brightness,
`endif
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              ca,
   output logic                    dp,
   output logic                    frame_done
);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

   if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS || REFRESH_DIV < 2 || BLANK_CYC >= REFRESH_DIV) begin : g_bad_cfg
      $error("svn_seg_scan_driver: illegal parameter combination");
   end

   logic [CW-1:0]           cnt;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic                    terminal, last, tail_zero, suppress, sel_dp, lit, pwm_on;
   logic [3:0]              sel_nib;
   logic [6:0]              seg;

   assign terminal = cnt == CW'(REFRESH_DIV - 1);
   assign last     = idx == IW'(NUM_DIGITS - 1);
   assign lit      = cnt >= CW'(BLANK_CYC) && !suppress;

`ifdef SVN_SEG_PWM_EN
   logic [3:0] pwm_cnt;
   assign pwm_on = brightness == 4'hF || pwm_cnt < brightness;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pwm_cnt <= '0;
      else pwm_cnt <= pwm_cnt + 1'b1;
`else
   assign pwm_on = 1'b1;
`endif

   // Walk from the top digit down so tail_zero holds "all digits >= j are empty" when j reaches idx.
   always_comb begin
      tail_zero = 1'b1;
      suppress  = 1'b0;
      sel_nib   = '0;
      sel_dp    = 1'b0;
      for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
         tail_zero = tail_zero && shadow_val[4*j +: 4] == 4'd0 && !shadow_dp[j];
         if (IW'(j) == idx) begin
            suppress = lz_blank && j > 0 && tail_zero;
            sel_nib  = shadow_val[4*j +: 4];
            sel_dp   = shadow_dp[j];
         end
      end
   end

   svn_seg_glyph_rom u_rom (.nib(sel_nib), .seg(seg));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         shadow_val <= '0;
         shadow_dp  <= '0;
         an         <= '1;
         ca         <= SEG_BLANK;
         dp         <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         cnt        <= terminal ? '0 : cnt + 1'b1;
         if (terminal) idx <= last ? '0 : idx + 1'b1;
         frame_done <= terminal && last;
         if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
         end
         an <= lit && pwm_on ? ~(NUM_DIGITS'(1) << idx) : '1;
         ca <= lit ? seg : SEG_BLANK;
         dp <= lit ? ~sel_dp : 1'b1;
      end
endmodule

// File: tb/tb_svn_seg_scan_driver.sv
// tb_svn_seg_scan_driver: table vectors, corner sequences and random stimulus against a slot-arithmetic reference model.
module tb_svn_seg_scan_driver;
   localparam int N = 4, RD = 8, BC = 2;

   logic        clk = 0, rst_n = 0, load = 0, lz_blank = 0;
   logic [15:0] value = 0;
   logic [3:0]  dp_in = 0;
`ifdef SVN_SEG_PWM_EN
   logic [3:0]  brightness = 4'hF;
`endif
   logic [3:0]  an;
   logic [6:0]  ca;
   logic        dp, frame_done;

   int          total = 0, bad = 0, t = 0, n;
   logic [15:0] m_val = 0;
   logic [3:0]  m_dp = 0;
   logic [6:0]  glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dpi;
      logic        lz;
      logic [3:0]  e_an [4];
      logic [6:0]  e_ca [4];
      logic [3:0]  e_dp;
   } vec_t;
   vec_t vt [3];

   always #5 clk = ~clk;

   svn_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
      .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load), .lz_blank(lz_blank),
`ifdef SVN_SEG_PWM_EN
      .brightness(brightness),
`endif
      .an(an), .ca(ca), .dp(dp), .frame_done(frame_done));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at t=%0d: got=%0h expected=%0h", name, t, got, exp);
      end
   endtask

   // Expected outputs after an edge are a pure function of how many edges have passed since reset.
   task automatic step();
      int         c, k;
      logic       blank, on;
      logic [3:0] nib, e_an;
      logic [6:0] e_ca;
      logic       e_dp, e_fd;
      c     = t % RD;
      k     = (t / RD) % N;
      nib   = 4'(m_val >> (4 * k));
      blank = c < BC || (lz_blank && k > 0 && (m_val >> (4 * k)) == 0 && (m_dp >> k) == 0);
      on    = 1'b1;
`ifdef SVN_SEG_PWM_EN
      on    = brightness == 4'hF || (t % 16) < brightness;
`endif
      e_an  = (blank || !on) ? 4'hF : ~(4'b0001 << k);
      e_ca  = blank ? 7'h7F : glyph[nib];
      e_dp  = blank ? 1'b1 : ~m_dp[k];
      e_fd  = (t + 1) % (N * RD) == 0;
      if (load) begin
         m_val = value;
         m_dp  = dp_in;
      end
      @(posedge clk);
      #1;
      t++;
      check("model_an", an, e_an);
      check("model_ca", ca, e_ca);
      check("model_dp", dp, e_dp);
      check("model_fd", frame_done, e_fd);
   endtask

   task automatic wait_frame();
      for (int i = 0; i < 2 * N * RD; i++) begin
         step();
         if (frame_done) return;
      end
      check("fd_timeout", 0, 1);
   endtask

   task automatic reset_release();
      @(posedge clk);
      #1;
      rst_n = 1;
      t = 0;
      m_val = 0;
      m_dp = 0;
   endtask

   initial begin
      vt[0] = '{16'h12AF, 4'b0000, 1'b0, '{4'b1110, 4'b1101, 4'b1011, 4'b0111},
                '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111}, 4'b1111};
      vt[1] = '{16'h0070, 4'b0000, 1'b1, '{4'b1110, 4'b1101, 4'b1111, 4'b1111},
                '{7'b0000001, 7'b0001111, 7'h7F, 7'h7F}, 4'b1111};
      vt[2] = '{16'h0000, 4'b0100, 1'b1, '{4'b1110, 4'b1101, 4'b1011, 4'b1111},
                '{7'b0000001, 7'b0000001, 7'b0000001, 7'h7F}, 4'b1011};

      #12;
      check("rst_an", an, 4'hF);
      check("rst_ca", ca, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_fd", frame_done, 1'b0);
      reset_release();
      step(); step();
      check("rel_blank_an", an, 4'hF);
      step();
      check("rel_first_an", an, 4'b1110);

      repeat (3) step();
      #2 rst_n = 0;
      #1;
      check("midrst_an", an, 4'hF);
      check("midrst_ca", ca, 7'h7F);
      check("midrst_dp", dp, 1'b1);
      reset_release();
      step(); step();
      check("rerel_blank_an", an, 4'hF);
      step();
      check("rerel_first_an", an, 4'b1110);

      for (int v = 0; v < 3; v++) begin
         value = vt[v].val; dp_in = vt[v].dpi; lz_blank = vt[v].lz; load = 1;
         step();
         load = 0;
         wait_frame();
         step();
         for (int s = 0; s < N; s++) begin
            check($sformatf("v%0d_s%0d_gap_an", v, s), an, 4'hF);
            repeat (BC) step();
            check($sformatf("v%0d_s%0d_an", v, s), an, vt[v].e_an[s]);
            check($sformatf("v%0d_s%0d_ca", v, s), ca, vt[v].e_ca[s]);
            check($sformatf("v%0d_s%0d_dp", v, s), dp, vt[v].e_dp[s]);
            repeat (RD - BC) step();
         end
         n = 0;
         while (!frame_done && n < 100) begin step(); n++; end
         check($sformatf("v%0d_fd_period", v), n, 31);
      end

      value = 16'h0011; dp_in = 0; lz_blank = 0; load = 1;
      step();
      load = 0;
      wait_frame();
      repeat (1 + RD + BC) step();
      check("midload_before_ca", ca, 7'b1001111);
      value = 16'h0022; load = 1;
      step();
      load = 0;
      check("midload_edge_ca", ca, 7'b1001111);
      step();
      check("midload_after_ca", ca, 7'b0010010);
      check("midload_after_an", an, 4'b1101);

      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 3))
            0: value = 16'($urandom) & 16'h000F;
            1: value = 16'($urandom) & 16'h00FF;
            2: value = 16'($urandom) & 16'h0FFF;
            default: value = 16'($urandom);
         endcase
         dp_in = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
         load = $urandom_range(0, 7) == 0;
         if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
`ifdef SVN_SEG_PWM_EN
         if ($urandom_range(0, 63) == 0) brightness = $urandom_range(0, 1) ? 4'($urandom) : 4'd4;
`endif
         step();
      end
      load = 0;

`ifdef SVN_SEG_PWM_EN
      brightness = 0;
      step();
      for (int i = 0; i < N * RD; i++) begin
         step();
         check("pwm0_an", an, 4'hF);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/svn_seg_scan_driver.md
Name: svn_seg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display, e.g. the 4-digit display on the BASYS 3.
- Latches a packed hex value and per-digit decimal points, then scans one digit per refresh slot.
- Drives active-low anodes, cathodes and DP, with an anti-ghosting blank gap and optional leading-zero suppression.
- Sits between the datapath (adder results, counters) and the board pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 2.
- BLANK_CYC, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*NUM_DIGITS  packed hex digits; nibble i drives digit i; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
- load  in  1  capture value/dp_in into shadow registers on this edge.
- lz_blank  in  1  enable leading-zero suppression; sampled live.
- an  out  NUM_DIGITS  anode enables, active-low.
- ca  out  7  cathodes, active-low; ca[6]=CA … ca[0]=CG.
- dp  out  1  decimal point cathode, active-low.
- frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - an = all 1, ca = 7'b1111111, dp = 1, frame_done = 0.
  - Prescaler, digit index and shadow registers are cleared to 0.
- Prescaler counts 0..REFRESH_DIV-1 and wraps to 0.
  - At terminal count, the digit index advances modulo NUM_DIGITS.
  - Scan order is 0, 1, …, NUM_DIGITS-1, 0.
- frame_done is registered. It is 1 for exactly the cycle in which the index has just returned to 0, i.e. once every NUM_DIGITS*REFRESH_DIV cycles.
- load=1 at a rising edge: shadow_val <= value and shadow_dp <= dp_in.
  - The new data is visible on outputs one cycle later.
  - Loading mid-slot changes the current digit immediately; there is no frame alignment.
- Glyph encoding (ca[6:0]):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
- Suppression: digit i is suppressed iff lz_blank=1, i>0, and for all j>=i both shadow nibble j==0 and shadow_dp[j]==0.
  - Digit 0 is never suppressed.
  - A lit DP stops suppression at its digit.
- Outputs are registered, so there is one cycle of latency from prescaler/index state. For current index k:
  - If prescaler < BLANK_CYC, or digit k is suppressed: an = all 1, ca = 7'h7F, dp = 1.
  - Otherwise: an has only bit k = 0, ca = glyph(nibble k), dp = ~shadow_dp[k].
- NUM_DIGITS=1: index stays 0 and frame_done pulses every slot.
- Reset asserted mid-scan: outputs blank immediately, with no wait for a clock edge. After release, scanning restarts at digit 0, prescaler 0.

Optional Feature:
- Macro: SVN_SEG_PWM_EN.
- Defined:
  - Adds input brightness [3:0] and a free-running 4-bit pwm counter, reset to 0, incrementing every cycle.
  - An enabled anode is additionally gated off unless brightness==15 or pwm_cnt < brightness.
  - ca and dp are unaffected.
  - brightness=0 gives all anodes off permanently.
- Undefined: no brightness port and no pwm counter; behaviour is identical to brightness=15.

Decomposition:
- Package svn_seg_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16-entry glyph constant table.
  - The legal NUM_DIGITS limits.
- Sub-module svn_seg_glyph_rom: purely combinational 4-bit to 7-bit lookup reading the package table, instantiated once on the selected nibble.
- Counters, suppression logic and output registers live in the top module.

Test Plan:
- Reset mid-slot (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2), rst_n low between edges -> an=4'b1111, ca=7'h7F, dp=1 immediately. After release, first lit anode is 4'b1110, 3 cycles later.
- load value=16'h12AF, lz_blank=0 -> per slot after the blank gap:
  - slot0: an=1110, ca=0111000.
  - slot1: an=1101, ca=0001000.
  - slot2: an=1011, ca=0010010.
  - slot3: an=0111, ca=1001111.
  - frame_done pulses every 32 cycles.
- value=16'h0070, lz_blank=1 -> digits 3 and 2 keep an high and ca=7F; digit1 shows 0001111; digit0 shows 0000001.
- value=16'h0000, dp_in=4'b0100, lz_blank=1 -> digit3 blank; digit2 ca=0000001 with dp=0; digits 1 and 0 show '0' with dp=1.
- load asserted mid-slot1 with value changing 16'h0011 -> 16'h0022 -> slot1 cathodes switch from 1001111 to 0010010 one cycle after the load edge.
- SVN_SEG_PWM_EN defined:
  - brightness=0 -> an all 1 for a full frame.
  - brightness=4 -> an active 4 of every 16 cycles inside the lit window.
  - brightness=15 -> an matches the non-PWM waveform.
